// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit
// Instruction-fetch front end. It sequences the fetch PC, drives a combinational
// instruction ROM, and buffers {pc, inst} pairs in a small prefetch FIFO so that
// fetching continues while decode stalls. A redirect (flush) empties the buffer
// and restarts fetching at the new target on the following cycle.
module if_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce_o,
  output logic [31:0]              rom_addr_o,
  input  logic [31:0]              rom_inst_i,
  input  logic                     flush_i,
  input  logic [31:0]              flush_pc_i,
  input  logic                     id_ready_i,
  output logic                     id_valid_o,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_inst_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C = PTR_W'(0);

  // Fetch addresses are always word aligned, including the reset vector.
  localparam logic [31:0] ALIGN_MASK_C = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_C   = RESET_PC & ALIGN_MASK_C;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [31:0]       fetch_pc_r;
  logic [31:0]       flush_target_s;

  logic [31:0]       pc_mem_r   [DEPTH];
  logic [31:0]       inst_mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              can_push_s;
  logic              pop_req_s;
  logic              push_s;
  logic              pop_s;

  // Head entry is presented whenever the buffer holds anything.
  assign id_valid_o     = (count_r != CNT_ZERO_C);
  assign fifo_count_o   = count_r;
  assign rom_addr_o     = fetch_pc_r;
  assign flush_target_s = flush_pc_i & ALIGN_MASK_C;

  // Handshake terms: a pop frees a slot, so a full buffer may still accept a push.
  always_comb begin
    pop_req_s  = id_valid_o & id_ready_i;
    can_push_s = (count_r < DEPTH_C) | pop_req_s;
    // A redirect discards any same-cycle push or pop.
    push_s     = rom_ce_o & ~flush_i;
    pop_s      = pop_req_s & ~flush_i;
  end

  // Next-state and ROM enable decode.
  always_comb begin
    state_nxt_s = state_r;
    rom_ce_o    = 1'b0;
    case (state_r)
      S_WAIT: begin
        rom_ce_o    = 1'b0;
        state_nxt_s = S_FETCH;
      end
      S_FETCH: begin
        rom_ce_o = can_push_s;
        // Buffer becomes full only by a push that is not matched by a pop.
        if (can_push_s && !pop_req_s && (count_r == DEPTH_M1_C)) begin
          state_nxt_s = S_FULL;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_FULL: begin
        rom_ce_o = 1'b0;
        // Fetching resumes the cycle after a slot is freed.
        if (pop_req_s) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_FULL;
        end
      end
      default: begin
        rom_ce_o    = 1'b0;
        state_nxt_s = S_WAIT;
      end
    endcase
  end

  // State register; a redirect always restarts fetching immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_WAIT;
    end else if (flush_i) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC: reset vector, redirect target, or sequential advance on a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC_C;
    end else if (flush_i) begin
      fetch_pc_r <= flush_target_s;
    end else if (push_s) begin
      fetch_pc_r <= fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= PTR_ZERO_C;
      wr_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else if (flush_i) begin
      rd_ptr_r <= PTR_ZERO_C;
      wr_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observable through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
      inst_mem_r[wr_ptr_r] <= rom_inst_i;
    end else begin
      pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
      inst_mem_r[wr_ptr_r] <= inst_mem_r[wr_ptr_r];
    end
  end

  // Head entry to decode, forced to zero when the buffer is empty.
  always_comb begin
    if (id_valid_o) begin
      id_pc_o   = pc_mem_r[rd_ptr_r];
      id_inst_o = inst_mem_r[rd_ptr_r];
    end else begin
      id_pc_o   = 32'h0000_0000;
      id_inst_o = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Testbench for if_prefetch_unit: directed scenarios with fixed expectations plus a
// randomized run checked against a queue-based reference model of the fetch buffer.
module tb_if_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, ready;
  logic [31:0] flush_pc;

  logic        ce, valid;
  logic [31:0] addr, rom_inst, pc, inst;
  logic [2:0]  count;

  logic        w_ce, w_valid;
  logic [31:0] w_addr, w_rom_inst, w_pc, w_inst;
  logic [2:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h3401ffff + {2'b00, a[31:2]};
  endfunction

  assign rom_inst   = rom_word(addr);
  assign w_rom_inst = rom_word(w_addr);

  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .rom_ce_o(ce), .rom_addr_o(addr), .rom_inst_i(rom_inst),
    .flush_i(flush), .flush_pc_i(flush_pc), .id_ready_i(ready), .id_valid_o(valid),
    .id_pc_o(pc), .id_inst_o(inst), .fifo_count_o(count)
  );

  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .rom_ce_o(w_ce), .rom_addr_o(w_addr), .rom_inst_i(w_rom_inst),
    .flush_i(flush), .flush_pc_i(flush_pc), .id_ready_i(ready), .id_valid_o(w_valid),
    .id_pc_o(w_pc), .id_inst_o(w_inst), .fifo_count_o(w_count)
  );

  // Reference model of the RESET_PC=0 instance: a queue of fetched entries.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_fpc;
  bit          m_wait;   // idle cycle after reset
  bit          m_stall;  // buffer filled up; fetch pauses until a pop

  logic        e_ce, e_valid;
  logic [31:0] e_addr, e_pc, e_inst;
  logic [2:0]  e_count;

  // Drive inputs, move to the falling edge and form the model's expectations.
  task automatic apply(input logic r, input logic f, input logic [31:0] fp, input logic rd);
    rst = r; flush = f; flush_pc = fp; ready = rd;
    @(negedge clk);
    e_valid = (mq.size() != 0);
    e_ce    = !m_wait && !m_stall && ((mq.size() < DEPTH) || (e_valid && rd));
    e_addr  = m_fpc;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_inst  = e_valid ? mq[0].inst : 32'h0;
    e_count = 3'(mq.size());
  endtask

  // Take the rising edge and advance the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_fpc = 32'h0; m_wait = 1'b1; m_stall = 1'b0;
    end else if (flush) begin
      mq.delete(); m_fpc = flush_pc & 32'hFFFF_FFFC; m_wait = 1'b0; m_stall = 1'b0;
    end else begin
      bit     do_pop, do_push;
      entry_t ne;
      do_pop  = e_valid && ready;
      do_push = e_ce;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        ne.pc = m_fpc; ne.inst = rom_word(m_fpc);
        mq.push_back(ne);
        m_fpc = m_fpc + 32'd4;
      end
      if (m_stall) m_stall = !do_pop;
      else if (do_push && !do_pop && mq.size() == DEPTH) m_stall = 1'b1;
      m_wait = 1'b0;
    end
    #1;
  endtask

  task automatic reset_dut(input int n, input logic rd);
    for (int k = 0; k < n; k++) begin apply(1'b1, 1'b0, 32'h0, rd); tick(); end
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 32'h0, 1'b1); tick();
    apply(1'b1, 1'b0, 32'h0, 1'b1);
    n_tests++; if (ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", ce); end
    n_tests++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (pc !== 32'h0 || inst !== 32'h0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", pc, inst); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (w_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_addr_w: got %h want fffffff8", w_addr); end
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b1); tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      logic [31:0] xa, xp;
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      xa = (i <= 1) ? 32'h0 : 32'((i - 1) * 4);
      xp = 32'((i - 2) * 4);
      n_tests++; if (ce !== (i >= 1)) begin n_fail++; $display("FAIL stream_ce c%0d: got %b want %b", i, ce, (i >= 1)); end
      n_tests++; if (addr !== xa) begin n_fail++; $display("FAIL stream_addr c%0d: got %h want %h", i, addr, xa); end
      n_tests++; if (valid !== (i >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", i, valid, (i >= 2)); end
      n_tests++; if (count !== ((i >= 2) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL stream_count c%0d: got %0d", i, count); end
      if (i >= 2) begin
        n_tests++; if (pc !== xp) begin n_fail++; $display("FAIL stream_pc c%0d: got %h want %h", i, pc, xp); end
        n_tests++; if (inst !== 32'h3401ffff + 32'(i - 2)) begin n_fail++; $display("FAIL stream_inst c%0d: got %h want %h", i, inst, 32'h3401ffff + 32'(i - 2)); end
      end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    reset_dut(2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0);
      if (i >= 5) begin
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count c%0d: got %0d want 4", i, count); end
        n_tests++; if (ce !== 1'b0) begin n_fail++; $display("FAIL fill_ce c%0d: got %b want 0", i, ce); end
        n_tests++; if (addr !== 32'h10) begin n_fail++; $display("FAIL fill_addr c%0d: got %h want 10", i, addr); end
      end
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      n_tests++; if (valid !== 1'b1 || pc !== 32'(4 * k)) begin n_fail++; $display("FAIL drain_pc k%0d: got v=%b pc=%h want v=1 pc=%h", k, valid, pc, 32'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_full_pulse();
    reset_dut(2, 1'b0);
    for (int i = 0; i < 6; i++) begin apply(1'b0, 1'b0, 32'h0, 1'b0); tick(); end
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (valid !== 1'b1 || pc !== 32'h0 || count !== 3'd4 || ce !== 1'b0) begin n_fail++; $display("FAIL pulse_pop: got v=%b pc=%h n=%0d ce=%b want 1/0/4/0", valid, pc, count, ce); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (count !== 3'd3 || pc !== 32'h4 || ce !== 1'b1 || addr !== 32'h10) begin n_fail++; $display("FAIL pulse_refetch: got n=%0d pc=%h ce=%b a=%h want 3/4/1/10", count, pc, ce, addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (count !== 3'd4 || pc !== 32'h4 || ce !== 1'b0 || addr !== 32'h14) begin n_fail++; $display("FAIL pulse_refull: got n=%0d pc=%h ce=%b a=%h want 4/4/0/14", count, pc, ce, addr); end
    tick();
  endtask

  task automatic test_flush();
    reset_dut(2, 1'b0);
    for (int i = 0; i < 4; i++) begin apply(1'b0, 1'b0, 32'h0, 1'b0); tick(); end
    apply(1'b0, 1'b1, 32'h0000_0023, 1'b1);
    n_tests++; if (count !== 3'd3 || valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL flush_pre: got n=%0d v=%b pc=%h want 3/1/0", count, valid, pc); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (count !== 3'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got n=%0d v=%b want 0/0", count, valid); end
    n_tests++; if (ce !== 1'b1 || addr !== 32'h20) begin n_fail++; $display("FAIL flush_target: got ce=%b a=%h want 1/20", ce, addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (valid !== 1'b1 || pc !== 32'h20 || inst !== rom_word(32'h20) || count !== 3'd1) begin n_fail++; $display("FAIL flush_head: got v=%b pc=%h i=%h n=%0d want 1/20/%h/1", valid, pc, inst, count, rom_word(32'h20)); end
    tick();
    apply(1'b0, 1'b1, 32'h0000_0100, 1'b1); tick();
    apply(1'b0, 1'b1, 32'h0000_0207, 1'b1); tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (addr !== 32'h204 || valid !== 1'b0 || ce !== 1'b1) begin n_fail++; $display("FAIL flush_b2b: got a=%h v=%b ce=%b want 204/0/1", addr, valid, ce); end
    tick();
  endtask

  task automatic test_wrap();
    reset_dut(2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] xa;
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      xa = (i <= 1) ? 32'hFFFF_FFF8 : 32'hFFFF_FFF8 + 32'(4 * (i - 1));
      n_tests++; if (w_addr !== xa || w_ce !== (i >= 1)) begin n_fail++; $display("FAIL wrap_addr c%0d: got a=%h ce=%b want %h/%b", i, w_addr, w_ce, xa, (i >= 1)); end
      if (i == 2) begin
        n_tests++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFF8 || w_inst !== rom_word(32'hFFFF_FFF8)) begin n_fail++; $display("FAIL wrap_head: got v=%b pc=%h i=%h", w_valid, w_pc, w_inst); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    reset_dut(2, 1'b0);
    for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b0, 32'h0, 1'b0); tick(); end
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL midrst_pre: got n=%0d want 2", count); end
    tick();
    apply(1'b1, 1'b1, 32'h0000_0040, 1'b1); tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (ce !== 1'b0 || addr !== 32'h0 || valid !== 1'b0 || pc !== 32'h0 || inst !== 32'h0 || count !== 3'd0) begin n_fail++; $display("FAIL midrst_outs: got ce=%b a=%h v=%b pc=%h i=%h n=%0d", ce, addr, valid, pc, inst, count); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (ce !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL midrst_fetch: got ce=%b a=%h want 1/0", ce, addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL midrst_head: got v=%b pc=%h want 1/0", valid, pc); end
    tick();
  endtask

  task automatic test_random();
    reset_dut(2, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic        r, f, rd;
      logic [31:0] fp;
      logic [100:0] obs, exp_v;
      r  = ($urandom_range(0, 149) == 0);
      f  = ($urandom_range(0, 24) == 0);
      fp = $urandom;
      rd = (((i / 60) % 2) == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      apply(r, f, fp, rd);
      obs   = {ce, addr, valid, pc, inst, count};
      exp_v = {e_ce, e_addr, e_valid, e_pc, e_inst, e_count};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random c%0d: got ce=%b a=%h v=%b pc=%h i=%h n=%0d want ce=%b a=%h v=%b pc=%h i=%h n=%0d",
                 i, ce, addr, valid, pc, inst, count, e_ce, e_addr, e_valid, e_pc, e_inst, e_count);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; ready = 1'b0;
    m_fpc = 32'h0; m_wait = 1'b1; m_stall = 1'b0;
    test_reset();
    test_stream();
    test_fill_drain();
    test_full_pulse();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
